// File: rtl/gearbox_seq_lock.sv
// Gearbox sequence counter with sync-header block-lock FSM and slip control.
// Latency: o_pause/o_step/o_slip combinational from state/inputs; o_locked one cycle after the deciding header.
// No backpressure: headers are sampled every cycle; headers during pause, SLIP and WAIT are dropped.
//
// Ports:
//   i_clk, i_reset      rising-edge clock, synchronous active-high reset
//   i_hdr_valid/i_hdr_ok sync header present / header is a legal 01 or 10 pattern
//   i_slip_ext          manual slip request, forces WAIT
//   o_count, o_pause    gearbox sequence count, high while count is at the pause value
//   o_step              count advances this cycle
//   o_slip, o_locked    slip pulse to the gearbox, block lock status
module gearbox_seq_lock #(
    parameter int WIDTH     = 6,
    parameter int MAX_VAL   = 32,
    parameter int PAUSE_VAL = 32,
    parameter int STEP_DIV  = 2,
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 64,
    parameter int BAD_LIMIT = 16,
    parameter int SLIP_WAIT = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_hdr_valid,
    input  logic             i_hdr_ok,
    input  logic             i_slip_ext,
    output logic [WIDTH-1:0] o_count,
    output logic             o_pause,
    output logic             o_step,
    output logic             o_slip,
    output logic             o_locked
);

    localparam int PW = $clog2(STEP_DIV) + 1;
    localparam int GW = $clog2(LOCK_CNT) + 1;
    localparam int HW = $clog2(WINDOW) + 1;
    localparam int BW = $clog2(BAD_LIMIT) + 1;
    localparam int WW = $clog2(SLIP_WAIT) + 1;

    typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [GW-1:0]    good_q, good_d;
    logic [HW-1:0]    hdr_q, hdr_d;
    logic [BW-1:0]    bad_q, bad_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic             hdr_take;
    logic             phase_last;

    assign phase_last = (phase_q == PW'(STEP_DIV - 1));
    assign o_count    = count_q;
    assign o_pause    = (count_q == WIDTH'(PAUSE_VAL));
    assign o_locked   = (state_q == LOCKED);
    assign o_slip     = (state_q == SLIP) | i_slip_ext;
    assign o_step     = phase_last & ~o_slip;
    // Headers landing on the pause slot carry no gearbox data and are not counted.
    assign hdr_take   = i_hdr_valid & ~o_pause;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        count_d = count_q;
        good_d  = good_q;
        hdr_d   = hdr_q;
        bad_d   = bad_q;
        wait_d  = wait_q;

        // Phase and count freeze while the gearbox is slipping.
        if (!o_slip) begin
            phase_d = phase_last ? '0 : phase_q + PW'(1);
        end
        if (o_step) begin
            count_d = (count_q == WIDTH'(MAX_VAL)) ? '0 : count_q + WIDTH'(1);
        end

        if (i_slip_ext) begin
            // Manual slip skips the SLIP state so the pulse is a single cycle.
            state_d = WAIT;
            good_d  = '0;
            hdr_d   = '0;
            bad_d   = '0;
            wait_d  = '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    if (hdr_take) begin
                        if (!i_hdr_ok) begin
                            state_d = SLIP;
                        end else if (good_q == GW'(LOCK_CNT - 1)) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + GW'(1);
                        end
                    end
                end
                SLIP: begin
                    state_d = WAIT;
                    good_d  = '0;
                    hdr_d   = '0;
                    bad_d   = '0;
                    wait_d  = '0;
                end
                WAIT: begin
                    if (wait_q == WW'(SLIP_WAIT - 1)) begin
                        state_d = SEARCH;
                    end else begin
                        wait_d = wait_q + WW'(1);
                    end
                end
                LOCKED: begin
                    if (hdr_take) begin
                        // Loss of lock wins over the end-of-window clear.
                        if (!i_hdr_ok && bad_q == BW'(BAD_LIMIT - 1)) begin
                            state_d = SLIP;
                        end else if (hdr_q == HW'(WINDOW - 1)) begin
                            hdr_d = '0;
                            bad_d = '0;
                        end else begin
                            hdr_d = hdr_q + HW'(1);
                            bad_d = bad_q + BW'(!i_hdr_ok);
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= SEARCH;
            phase_q <= '0;
            count_q <= '0;
            good_q  <= '0;
            hdr_q   <= '0;
            bad_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            count_q <= count_d;
            good_q  <= good_d;
            hdr_q   <= hdr_d;
            bad_q   <= bad_d;
            wait_q  <= wait_d;
        end
    end

endmodule

// File: tb/tb_gearbox_seq_lock.sv
// Randomised and directed bench for gearbox_seq_lock against a behavioural model.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
// The model advances once per rising edge.
module tb_gearbox_seq_lock;

    localparam int WIDTH     = 6;
    localparam int MAX_VAL   = 32;
    localparam int PAUSE_VAL = 32;
    localparam int STEP_DIV  = 2;
    localparam int LOCK_CNT  = 64;
    localparam int WINDOW    = 64;
    localparam int BAD_LIMIT = 16;
    localparam int SLIP_WAIT = 4;

    logic             clk = 1'b0;
    logic             reset, hdr_valid, hdr_ok, slip_ext;
    logic [WIDTH-1:0] o_count;
    logic             o_pause, o_step, o_slip, o_locked;

    int checks = 0;
    int errors = 0;
    int slips_seen = 0;
    bit armed = 0;

    // Behavioural model: the link is either hunting for lock, slipping,
    // quiet after a slip, or locked.
    typedef enum int {M_HUNT, M_SLIPPING, M_QUIET, M_LOCK} mode_t;
    mode_t m_mode;
    int m_cnt, m_ph, m_good, m_hdrs, m_bads, m_quiet_left;

    gearbox_seq_lock #(
        .WIDTH(WIDTH), .MAX_VAL(MAX_VAL), .PAUSE_VAL(PAUSE_VAL), .STEP_DIV(STEP_DIV),
        .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .BAD_LIMIT(BAD_LIMIT), .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_hdr_valid(hdr_valid), .i_hdr_ok(hdr_ok),
        .i_slip_ext(slip_ext), .o_count(o_count), .o_pause(o_pause), .o_step(o_step),
        .o_slip(o_slip), .o_locked(o_locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_link();
        m_good = 0;
        m_hdrs = 0;
        m_bads = 0;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic cyc(input logic v, input logic ok, input logic se, input logic rst);
        bit e_slip, e_step, e_pause, counted;
        @(negedge clk);
        hdr_valid = v;
        hdr_ok    = ok;
        slip_ext  = se;
        reset     = rst;
        #1;
        e_slip  = (m_mode == M_SLIPPING) || se;
        e_step  = !e_slip && (m_ph == STEP_DIV - 1);
        e_pause = (m_cnt == PAUSE_VAL);
        if (armed) begin
            chk("count",  32'(o_count), 32'(m_cnt));
            chk("pause",  32'(o_pause), 32'(e_pause));
            chk("step",   32'(o_step),  32'(e_step));
            chk("slip",   32'(o_slip),  32'(e_slip));
            chk("locked", 32'(o_locked), 32'(m_mode == M_LOCK));
        end
        if (o_slip === 1'b1) slips_seen++;

        if (rst) begin
            m_cnt  = 0;
            m_ph   = 0;
            m_mode = M_HUNT;
            clear_link();
            m_quiet_left = 0;
            armed = 1;
        end else begin
            if (!e_slip) m_ph = (m_ph + 1) % STEP_DIV;
            if (e_step) m_cnt = (m_cnt == MAX_VAL) ? 0 : m_cnt + 1;
            counted = v && !e_pause;
            if (se) begin
                m_mode = M_QUIET;
                m_quiet_left = SLIP_WAIT;
                clear_link();
            end else begin
                case (m_mode)
                    M_HUNT: if (counted) begin
                        if (!ok) m_mode = M_SLIPPING;
                        else begin
                            m_good++;
                            if (m_good == LOCK_CNT) begin
                                m_mode = M_LOCK;
                                m_good = 0;
                            end
                        end
                    end
                    M_SLIPPING: begin
                        m_mode = M_QUIET;
                        m_quiet_left = SLIP_WAIT;
                        clear_link();
                    end
                    M_QUIET: begin
                        m_quiet_left--;
                        if (m_quiet_left == 0) m_mode = M_HUNT;
                    end
                    M_LOCK: if (counted) begin
                        m_hdrs++;
                        if (!ok) m_bads++;
                        if (m_bads == BAD_LIMIT) m_mode = M_SLIPPING;
                        else if (m_hdrs == WINDOW) clear_link();
                    end
                    default: m_mode = M_HUNT;
                endcase
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    // Deliver n counted headers (pause-slot headers are extra and random),
    // exactly nbad of them bad; optionally the final one is bad.
    task automatic send_hdrs(input int n, input int nbad, input bit last_bad);
        int done = 0, bleft, guard = 0, slots;
        bit b;
        bleft = last_bad ? nbad - 1 : nbad;
        while (done < n && guard < 4000) begin
            if (m_cnt != PAUSE_VAL) begin
                if (last_bad && done == n - 1) b = 1;
                else begin
                    slots = (last_bad ? n - 1 : n) - done;
                    b = (bleft > 0) && (int'($urandom_range(slots - 1, 0)) < bleft);
                    if (b) bleft--;
                end
                done++;
            end else begin
                b = 1'($urandom_range(1, 0));
            end
            cyc(1, !b, 0, 0);
            guard++;
        end
        if (guard >= 4000) chk("send_guard", 32'(done), 32'(n));
    endtask

    task automatic wait_not_pause();
        int g = 0;
        while (m_cnt == PAUSE_VAL && g < 10) begin
            cyc(0, 0, 0, 0);
            g++;
        end
    endtask

    initial begin
        int pcnt, scnt, g, badpct;
        hdr_valid = 0; hdr_ok = 0; slip_ext = 1; reset = 1;
        m_mode = M_HUNT; m_cnt = 0; m_ph = 0; m_quiet_left = 0;
        clear_link();

        // Reset overrides a simultaneous manual slip.
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 0, 0);
        chk("rst_count", 32'(o_count), 0);
        chk("rst_locked", 32'(o_locked), 0);
        chk("rst_step", 32'(o_step), 32'(STEP_DIV == 1));
        chk("rst_slip", 32'(o_slip), 0);
        cyc(0, 0, 1, 0);
        chk("rst_slip_ext", 32'(o_slip), 1);

        // Free run: one full 66-cycle period of the sequence counter.
        idle(1);
        pcnt = 0; scnt = 0;
        for (int i = 0; i < 66; i++) begin
            cyc(0, 0, 0, 0);
            pcnt += int'(o_pause);
            scnt += int'(o_step);
        end
        chk("period_pause_cycles", 32'(pcnt), 2);
        chk("period_steps", 32'(scnt), 33);

        // Lock after exactly LOCK_CNT good headers, no slip on the way.
        slips_seen = 0;
        send_hdrs(LOCK_CNT - 1, 0, 0);
        idle(1);
        chk("lock_early", 32'(o_locked), 0);
        send_hdrs(1, 0, 0);
        chk("lock_same_cycle", 32'(o_locked), 0);
        idle(1);
        chk("lock_rise", 32'(o_locked), 1);
        chk("lock_no_slip", 32'(slips_seen), 0);

        // Window with one bad short of the limit keeps lock and clears.
        send_hdrs(WINDOW, BAD_LIMIT - 1, 0);
        idle(1);
        chk("win15_locked", 32'(o_locked), 1);
        // Limit reached on the last header of the window: slip wins.
        slips_seen = 0;
        send_hdrs(WINDOW, BAD_LIMIT, 1);
        idle(1);
        chk("win16_unlock", 32'(o_locked), 0);
        chk("win16_slip", 32'(o_slip), 1);
        idle(8);
        chk("win16_one_pulse", 32'(slips_seen), 1);

        // SEARCH: 10 good then a bad one, bad headers ignored during WAIT.
        send_hdrs(10, 0, 0);
        send_hdrs(1, 1, 1);
        idle(1);
        chk("search_slip", 32'(o_slip), 1);
        for (int i = 0; i < SLIP_WAIT; i++) cyc(1, 0, 0, 0);
        slips_seen = 0;
        send_hdrs(LOCK_CNT - 1, 0, 0);
        idle(1);
        chk("relock_early", 32'(o_locked), 0);
        chk("wait_ignored", 32'(slips_seen), 0);
        send_hdrs(1, 0, 0);
        idle(1);
        chk("relock", 32'(o_locked), 1);

        // Manual slip while locked.
        cyc(0, 0, 1, 0);
        chk("ext_slip_now", 32'(o_slip), 1);
        chk("ext_locked_now", 32'(o_locked), 1);
        idle(1);
        chk("ext_unlock", 32'(o_locked), 0);
        chk("ext_single", 32'(o_slip), 0);
        for (int i = 0; i < SLIP_WAIT - 1; i++) cyc(1, 0, 0, 0);

        // Manual slip coinciding with a bad header in SEARCH.
        wait_not_pause();
        cyc(1, 0, 1, 0);
        idle(1);
        chk("coinc_single", 32'(o_slip), 0);
        idle(SLIP_WAIT + 2);

        // Header offered only during pause does not count toward lock.
        cyc(0, 0, 0, 1);
        g = 0;
        while (m_cnt != PAUSE_VAL && g < 100) begin
            cyc(0, 0, 0, 0);
            g++;
        end
        chk("reach_pause", 32'(m_cnt == PAUSE_VAL), 1);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        send_hdrs(LOCK_CNT - 1, 0, 0);
        idle(1);
        chk("pause_hdr_ignored", 32'(o_locked), 0);
        send_hdrs(1, 0, 0);
        idle(1);
        chk("pause_lock", 32'(o_locked), 1);

        // Reset while locked.
        cyc(0, 0, 0, 1);
        idle(1);
        chk("rst_locked_count", 32'(o_count), 0);
        chk("rst_locked_lock", 32'(o_locked), 0);

        // Reset during WAIT.
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 1);
        idle(1);
        chk("rst_wait_slip", 32'(o_slip), 0);

        // Random traffic in segments of varying bad-header density.
        for (int seg = 0; seg < 8; seg++) begin
            case (seg % 4)
                0: badpct = 0;
                1: badpct = 3;
                2: badpct = 25;
                default: badpct = 40;
            endcase
            for (int i = 0; i < 600; i++) begin
                cyc(1'($urandom_range(99, 0) < 70),
                    1'($urandom_range(99, 0) >= badpct),
                    1'($urandom_range(999, 0) < 5),
                    1'($urandom_range(999, 0) < 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
